// File: rtl/sprite_write_arbiter_pkg.sv
// Shared types for the sprite_bram write arbiter: field encoding, queued host write record, FSM states.
package sprite_write_arbiter_pkg;

  localparam int SPRITE_IDX_W  = 9;
  localparam int SPRITE_DATA_W = 32;

  typedef enum logic [1:0] {
    FIELD_Y_HEIGHT = 2'd0,
    FIELD_X_WIDTH  = 2'd1,
    FIELD_ADDR     = 2'd2,
    FIELD_VELOCITY = 2'd3
  } sprite_field_e;

  typedef struct packed {
    logic [SPRITE_IDX_W-1:0]  index;
    sprite_field_e            field;
    logic [SPRITE_DATA_W-1:0] data;
  } host_wr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_MOTION,
    S_GUARD
  } arb_state_e;

  // Motion pass rewrites y_height and x_width of one sprite together.
  localparam logic [3:0] MOTION_FIELD_EN = 4'b0011;

  function automatic logic [3:0] field_onehot(sprite_field_e f);
    return 4'b0001 << f;
  endfunction

endpackage

// File: rtl/sprite_write_arbiter_if.sv
// Host register-write channel (valid/ready) into the sprite write arbiter.
interface sprite_write_arbiter_if;
  import sprite_write_arbiter_pkg::*;

  logic                     host_valid;
  logic                     host_ready;
  logic [SPRITE_IDX_W-1:0]  host_index;
  logic [1:0]               host_field;
  logic [SPRITE_DATA_W-1:0] host_data;

  modport master (
    output host_valid, host_index, host_field, host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid, host_index, host_field, host_data,
    output host_ready
  );

endinterface

// File: rtl/sprite_write_arbiter_fifo.sv
// Synchronous FIFO of queued host writes; occupancy is a registered count so full/empty never glitch.
module sprite_wr_fifo
  import sprite_write_arbiter_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_draw,
  input  logic             rst_draw,
  input  logic             push_i,
  input  host_wr_t         wr_i,
  input  logic             pop_i,
  output host_wr_t         rd_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  host_wr_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rd_o    = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage has no reset; an entry is only visible once the count covers it.
  always_ff @(posedge clk_draw) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_i;
  end

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/sprite_write_arbiter.sv
// Arbitrates the single sprite_bram write port between queued host writes and the motion updater.
module sprite_write_arbiter
  import sprite_write_arbiter_pkg::*;
#(
  parameter  int FIFO_DEPTH     = 8,
  parameter  int DATA_W         = SPRITE_DATA_W,
  parameter  int MOTION_TIMEOUT = 1024,
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1,
  localparam int CNT_W          = $clog2(MOTION_TIMEOUT + 1)
) (
  input  logic                    clk_draw,
  input  logic                    rst_draw,
  sprite_write_arbiter_if.slave   host,
  input  logic                    motion_req,
  input  logic                    motion_en,
  input  logic [SPRITE_IDX_W-1:0] motion_index,
  input  logic [DATA_W-1:0]       motion_y_height,
  input  logic [DATA_W-1:0]       motion_x_width,
  output logic [SPRITE_IDX_W-1:0] w_index,
  output logic [DATA_W-1:0]       w_data,
  output logic [DATA_W-1:0]       w_y_height,
  output logic [DATA_W-1:0]       w_x_width,
  output logic [3:0]              w_field_en,
  output logic [LVL_W-1:0]        fifo_level,
  output logic                    motion_timeout
);

  arb_state_e state_q, state_d;
  host_wr_t   push_entry, head;
  logic       push, pop, fifo_full, fifo_empty, motion_wr;

  logic [SPRITE_IDX_W-1:0] w_index_q, w_index_d;
  logic [DATA_W-1:0]       w_data_q, w_data_d, w_y_height_q, w_y_height_d, w_x_width_q, w_x_width_d;
  logic [3:0]              w_field_en_q, w_field_en_d;
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    timeout_q, timeout_d;

  assign host.host_ready = !fifo_full;
  assign push            = host.host_valid && !fifo_full;
  assign push_entry      = '{index: host.host_index,
                             field: sprite_field_e'(host.host_field),
                             data:  host.host_data};
  assign motion_wr       = motion_req && motion_en;

  sprite_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_draw (clk_draw),
    .rst_draw (rst_draw),
    .push_i   (push),
    .wr_i     (push_entry),
    .pop_i    (pop),
    .rd_o     (head),
    .level_o  (fifo_level),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (motion_req)                state_d = S_MOTION;
        else if (push || !fifo_empty)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (motion_req) begin
          state_d = S_MOTION;
        end else begin
          pop = !fifo_empty;
          if (!push && fifo_level <= LVL_W'(1)) state_d = S_IDLE;
        end
      end
      S_MOTION: begin
        if (!motion_req) state_d = S_GUARD;
      end
      S_GUARD: begin
        if (motion_req)                state_d = S_MOTION;
        else if (push || !fifo_empty)  state_d = S_DRAIN;
        else                           state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Motion writes and pops are exclusive: pops only happen while motion_req is low.
  always_comb begin
    w_index_d    = w_index_q;
    w_data_d     = w_data_q;
    w_y_height_d = w_y_height_q;
    w_x_width_d  = w_x_width_q;
    w_field_en_d = 4'b0000;
    if (motion_wr) begin
      w_index_d    = motion_index;
      w_y_height_d = motion_y_height;
      w_x_width_d  = motion_x_width;
      w_field_en_d = MOTION_FIELD_EN;
    end else if (pop) begin
      w_index_d    = head.index;
      w_data_d     = head.data;
      w_y_height_d = head.data;
      w_x_width_d  = head.data;
      w_field_en_d = field_onehot(head.field);
    end
  end

  always_comb begin
    tmo_cnt_d = '0;
    if (motion_req)
      tmo_cnt_d = (tmo_cnt_q == CNT_W'(MOTION_TIMEOUT)) ? tmo_cnt_q : tmo_cnt_q + CNT_W'(1);
    timeout_d = timeout_q || (motion_req && tmo_cnt_q == CNT_W'(MOTION_TIMEOUT - 1));
  end

  always_ff @(posedge clk_draw or posedge rst_draw) begin
    if (rst_draw) begin
      state_q      <= S_IDLE;
      w_index_q    <= '0;
      w_data_q     <= '0;
      w_y_height_q <= '0;
      w_x_width_q  <= '0;
      w_field_en_q <= '0;
      tmo_cnt_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_index_q    <= w_index_d;
      w_data_q     <= w_data_d;
      w_y_height_q <= w_y_height_d;
      w_x_width_q  <= w_x_width_d;
      w_field_en_q <= w_field_en_d;
      tmo_cnt_q    <= tmo_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign w_index        = w_index_q;
  assign w_data         = w_data_q;
  assign w_y_height     = w_y_height_q;
  assign w_x_width      = w_x_width_q;
  assign w_field_en     = w_field_en_q;
  assign motion_timeout = timeout_q;

endmodule

// File: tb/tb_sprite_write_arbiter.sv
// Directed bench for sprite_write_arbiter: host ordering, motion priority, guard cycle, reset, timeout.
module tb_sprite_write_arbiter;
  import sprite_write_arbiter_pkg::*;

  logic        clk_draw = 1'b0;
  logic        rst_draw;
  logic        motion_req, motion_en;
  logic [8:0]  motion_index;
  logic [31:0] motion_y_height, motion_x_width;
  logic [8:0]  w_index;
  logic [31:0] w_data, w_y_height, w_x_width;
  logic [3:0]  w_field_en;
  logic [3:0]  fifo_level;
  logic        motion_timeout;

  int total = 0;
  int bad   = 0;

  sprite_write_arbiter_if hif ();

  sprite_write_arbiter dut (
    .clk_draw        (clk_draw),
    .rst_draw        (rst_draw),
    .host            (hif),
    .motion_req      (motion_req),
    .motion_en       (motion_en),
    .motion_index    (motion_index),
    .motion_y_height (motion_y_height),
    .motion_x_width  (motion_x_width),
    .w_index         (w_index),
    .w_data          (w_data),
    .w_y_height      (w_y_height),
    .w_x_width       (w_x_width),
    .w_field_en      (w_field_en),
    .fifo_level      (fifo_level),
    .motion_timeout  (motion_timeout)
  );

  always #5 clk_draw = ~clk_draw;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_draw);
    #1;
  endtask

  task automatic host_set(input logic v, input logic [8:0] idx, input logic [1:0] f,
                          input logic [31:0] d);
    hif.host_valid = v;
    hif.host_index = idx;
    hif.host_field = f;
    hif.host_data  = d;
  endtask

  task automatic motion_set(input logic req, input logic en, input logic [8:0] idx,
                            input logic [31:0] yh, input logic [31:0] xw);
    motion_req      = req;
    motion_en       = en;
    motion_index    = idx;
    motion_y_height = yh;
    motion_x_width  = xw;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_draw = 1'b1;
    host_set(0, 0, 0, 0);
    motion_set(0, 0, 0, 0, 0);
    repeat (3) tick();

    // Reset state
    check("rst_en",      w_field_en, 4'b0000);
    check("rst_index",   w_index, 9'd0);
    check("rst_data",    w_data, 32'd0);
    check("rst_yh",      w_y_height, 32'd0);
    check("rst_xw",      w_x_width, 32'd0);
    check("rst_level",   fifo_level, 4'd0);
    check("rst_ready",   hif.host_ready, 1'b1);
    check("rst_timeout", motion_timeout, 1'b0);
    rst_draw = 1'b0;
    tick();

    // 1: three host writes, in order, first one two cycles after accept
    host_set(1, 9'd5, 2'd0, 32'h1111_0000);
    tick();
    host_set(1, 9'd5, 2'd1, 32'h2222_0001);
    check("t1_latency", w_field_en, 4'b0000);
    tick();
    host_set(1, 9'd5, 2'd3, 32'h3333_0003);
    check("t1_w0_en",   w_field_en, 4'b0001);
    check("t1_w0_idx",  w_index, 9'd5);
    check("t1_w0_data", w_data, 32'h1111_0000);
    tick();
    host_set(0, 0, 0, 0);
    check("t1_w1_en",   w_field_en, 4'b0010);
    check("t1_w1_data", w_data, 32'h2222_0001);
    tick();
    check("t1_w2_en",   w_field_en, 4'b1000);
    check("t1_w2_data", w_data, 32'h3333_0003);
    tick();
    check("t1_idle_en", w_field_en, 4'b0000);
    check("t1_level",   fifo_level, 4'd0);

    // 2: nine pushes during a motion window; eight fit
    motion_set(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      host_set(1, 9'(i), 2'(i % 4), 32'hA000_0000 + 32'(i));
      tick();
    end
    check("t2_ready_full", hif.host_ready, 1'b0);
    check("t2_level_full", fifo_level, 4'd8);
    check("t2_no_host_en", w_field_en, 4'b0000);
    host_set(1, 9'd8, 2'd0, 32'hA000_0008);
    tick();
    host_set(0, 0, 0, 0);
    check("t2_level_9th",  fifo_level, 4'd8);
    check("t2_en_window",  w_field_en, 4'b0000);
    motion_set(0, 0, 0, 0, 0);
    tick();
    tick();
    check("t2_guard_idle", w_field_en, 4'b0000);
    tick();
    for (int j = 0; j < 8; j++) begin
      check($sformatf("t2_pop%0d_en", j),   w_field_en, 4'b0001 << (j % 4));
      check($sformatf("t2_pop%0d_idx", j),  w_index, 9'(j));
      check($sformatf("t2_pop%0d_data", j), w_data, 32'hA000_0000 + 32'(j));
      tick();
    end
    check("t2_after_en",    w_field_en, 4'b0000);
    check("t2_after_level", fifo_level, 4'd0);
    check("t2_after_ready", hif.host_ready, 1'b1);

    // 3: motion preempts a drain of four entries
    for (int k = 0; k < 4; k++) begin
      host_set(1, 9'd20 + 9'(k), 2'(k), 32'hC000_0000 + 32'(k));
      tick();
    end
    host_set(0, 0, 0, 0);
    motion_set(1, 1, 9'd7, 32'h0707_0001, 32'h0707_0002);
    check("t3_e2_en",    w_field_en, 4'b0100);
    check("t3_e2_idx",   w_index, 9'd22);
    check("t3_level",    fifo_level, 4'd1);
    tick();
    motion_set(0, 0, 0, 0, 0);
    check("t3_mot_en",   w_field_en, 4'b0011);
    check("t3_mot_idx",  w_index, 9'd7);
    check("t3_mot_yh",   w_y_height, 32'h0707_0001);
    check("t3_mot_xw",   w_x_width, 32'h0707_0002);
    tick();
    check("t3_exit_idle", w_field_en, 4'b0000);
    tick();
    check("t3_guard_idle", w_field_en, 4'b0000);
    tick();
    check("t3_e3_en",    w_field_en, 4'b1000);
    check("t3_e3_idx",   w_index, 9'd23);
    check("t3_e3_data",  w_data, 32'hC000_0003);
    tick();
    check("t3_done_en",  w_field_en, 4'b0000);
    check("t3_done_lvl", fifo_level, 4'd0);

    // 4: host write queued during a motion write to the same index lands last
    motion_set(1, 1, 9'd12, 32'h0000_1234, 32'h0000_5678);
    host_set(1, 9'd12, 2'd0, 32'hBEEF_0012);
    tick();
    motion_set(0, 0, 0, 0, 0);
    host_set(0, 0, 0, 0);
    check("t4_mot_en",  w_field_en, 4'b0011);
    check("t4_mot_yh",  w_y_height, 32'h0000_1234);
    tick();
    tick();
    tick();
    check("t4_host_en",  w_field_en, 4'b0001);
    check("t4_host_idx", w_index, 9'd12);
    check("t4_host_yh",  w_y_height, 32'hBEEF_0012);
    motion_set(0, 1, 9'd99, 32'hDEAD_0000, 32'hDEAD_0001);
    tick();
    check("t4_en_ignored", w_field_en, 4'b0000);
    motion_set(0, 0, 0, 0, 0);

    // 5: reset with five entries queued
    motion_set(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      host_set(1, 9'd40 + 9'(k), 2'd2, 32'h5500_0000 + 32'(k));
      tick();
    end
    host_set(0, 0, 0, 0);
    check("t5_level_pre", fifo_level, 4'd5);
    #2;
    rst_draw = 1'b1;
    #1;
    check("t5_level_rst", fifo_level, 4'd0);
    check("t5_en_rst",    w_field_en, 4'b0000);
    check("t5_ready_rst", hif.host_ready, 1'b1);
    motion_set(0, 0, 0, 0, 0);
    tick();
    tick();
    rst_draw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t5_nostale%0d", k), w_field_en, 4'b0000);
    end
    check("t5_level_post", fifo_level, 4'd0);

    // 6: motion window of 1025 cycles trips the sticky timeout at the 1024th
    motion_set(1, 0, 0, 0, 0);
    repeat (1023) tick();
    check("t6_before", motion_timeout, 1'b0);
    tick();
    check("t6_at_1024", motion_timeout, 1'b1);
    tick();
    motion_set(0, 0, 0, 0, 0);
    tick();
    tick();
    check("t6_sticky", motion_timeout, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
